// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder-sharing arbiter.
// The states are IDLE, EXEC and RESP. next_ptr advances the round-robin pointer.
package adder_share_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int next_ptr(input int g, input int nreq);
    return (g >= nreq - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_grant_sel.sv
// Combinational round-robin picker.
// It returns the first valid requester at or after the round-robin pointer.
module rr_grant_sel
  import adder_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [IDW-1:0]  i_rr_ptr,
  output logic            o_grant_valid,
  output logic [IDW-1:0]  o_grant_idx
);

  int w_j;

  // The scan runs from the farthest offset down to offset 0, so the nearest valid requester wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_j           = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(i_rr_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_req_valid[w_j[IDW-1:0]]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external adder between NREQ requesters.
// Defining ADDER_SHARE_OVF_EN adds the registered signed-overflow output rsp_ovf.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  NREQ  = DEF_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  output logic              add_cin,
  output logic              add_en,
  input  logic [WIDTH-1:0]  add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [WIDTH-1:0]  rsp_sum,
  output logic              rsp_cout
`ifdef ADDER_SHARE_OVF_EN
  ,
  output logic              rsp_ovf
`endif
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_grant_idx;
  logic           w_grant_valid;
  logic           w_accept;

  rr_grant_sel #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_grant_sel (
    .i_req_valid   (req_valid),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_ready   = '0;
    add_en      = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: w_accept = w_grant_valid;
      ST_EXEC: begin
        add_en      = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_accept    = w_grant_valid;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A new grant may be taken in the same cycle the response is consumed.
    w_accept = w_accept && rst_n;
    if (w_accept) begin
      req_ready[w_grant_idx] = 1'b1;
      w_state_nxt            = ST_EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      // The operand registers load only on accept, so the adder inputs do not toggle while idle.
      if (w_accept) begin
        add_a    <= req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
        add_b    <= req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
        add_cin  <= req_cin[w_grant_idx];
        r_id     <= w_grant_idx;
        r_rr_ptr <= IDW'(next_ptr(int'(w_grant_idx), NREQ));
      end
      if (r_state == ST_EXEC) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_id   <= r_id;
`ifdef ADDER_SHARE_OVF_EN
        rsp_ovf  <= (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter. The bench provides a behavioural adder and a transaction-level reference model.
module tb_adder_share_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_ready, req_cin;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_sum;
  logic                  add_cin, add_en, add_cout;
  logic                  rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0]        rsp_id;
`ifdef ADDER_SHARE_OVF_EN
  logic                  rsp_ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_en    (add_en),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] s;
    s = ref_add(a, b, c);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 0; off < NREQ; off++)
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] oh;
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    return oh;
  endfunction

  function automatic logic [31:0] get_a(input int i);
    return req_a[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [31:0] get_b(input int i);
    return req_b[i*WIDTH +: WIDTH];
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i] = c;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (req_ready !== '0) $display("FAIL reset_ready got=%b exp=0", req_ready); else n_pass++;
    n_total++;
    if ({add_a, add_b, add_cin, add_en, rsp_valid, rsp_id, rsp_sum, rsp_cout} !== '0)
      $display("FAIL reset_outputs add_a=%h add_b=%h cin=%b en=%b rv=%b id=%0d sum=%h cout=%b exp=all zero",
               add_a, add_b, add_cin, add_en, rsp_valid, rsp_id, rsp_sum, rsp_cout);
    else n_pass++;
    @(negedge clk);
    req_valid = '0; rst_n = 1'b1; m_ptr = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 32'd5, 32'd7, 1'b1); req_valid = 4'b0001; rsp_ready = 1'b0; #1;
    n_total++;
    if (req_ready !== 4'b0001 || add_en !== 1'b0) $display("FAIL single_accept ready=%b en=%b exp ready=0001 en=0", req_ready, add_en); else n_pass++;
    @(negedge clk); req_valid = '0; #1;
    n_total++;
    if (add_en !== 1'b1 || add_a !== 32'd5 || add_b !== 32'd7 || add_cin !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL single_exec en=%b a=%0d b=%0d cin=%b rv=%b exp en=1 a=5 b=7 cin=1 rv=0", add_en, add_a, add_b, add_cin, rsp_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd13 || rsp_cout !== 1'b0 || add_en !== 1'b0)
      $display("FAIL single_resp rv=%b id=%0d sum=%0d cout=%b en=%b exp rv=1 id=0 sum=13 cout=0 en=0", rsp_valid, rsp_id, rsp_sum, rsp_cout, add_en);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0; #1;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_drain rv=%b exp=0", rsp_valid); else n_pass++;
    m_ptr = 1;
  endtask

  task automatic test_carry();
    logic [31:0] va [2];
    logic [31:0] vb [2];
    logic        vc [2];
    int          vi [2];
    logic [32:0] r;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0;         vc[0] = 1'b1; vi[0] = 3;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h7FFF_FFFF; vc[1] = 1'b0; vi[1] = 1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      set_req(vi[t], va[t], vb[t], vc[t]); req_valid = onehot(vi[t]); #1;
      n_total++;
      if (req_ready !== onehot(vi[t])) $display("FAIL carry_ready t=%0d got=%b exp=%b", t, req_ready, onehot(vi[t])); else n_pass++;
      m_ptr = (vi[t] + 1) % NREQ;
      @(negedge clk); req_valid = '0;
      @(negedge clk); #1;
      r = ref_add(va[t], vb[t], vc[t]);
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(vi[t]) || {rsp_cout, rsp_sum} !== r)
        $display("FAIL carry_resp t=%0d rv=%b id=%0d cout=%b sum=%h exp id=%0d cout=%b sum=%h", t, rsp_valid, rsp_id, rsp_cout, rsp_sum, vi[t], r[32], r[31:0]);
      else n_pass++;
`ifdef ADDER_SHARE_OVF_EN
      n_total++;
      if (rsp_ovf !== ref_ovf(va[t], vb[t], vc[t])) $display("FAIL carry_ovf t=%0d got=%b exp=%b", t, rsp_ovf, ref_ovf(va[t], vb[t], vc[t])); else n_pass++;
`endif
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;
    end
  endtask

  task automatic test_all_rr();
    int          acc_cnt = 0, rsp_cnt = 0, last_acc = -1, g, exp_id;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_a = '0;
    logic [32:0] res;
    int          q_id[$];
    logic [32:0] q_res[$];
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 1'($urandom));
    @(negedge clk);
    req_valid = '1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && rsp_cnt < 8; cyc++) begin
      #1;
      n_total++;
      if (add_en !== prev_acc) $display("FAIL rr_add_en cyc=%0d got=%b exp=%b", cyc, add_en, prev_acc); else n_pass++;
      if (prev_acc) begin
        n_total++;
        if (add_a !== prev_a) $display("FAIL rr_add_a cyc=%0d got=%h exp=%h", cyc, add_a, prev_a); else n_pass++;
      end
      if (rsp_valid) begin
        n_total++;
        if (q_id.size() == 0) $display("FAIL rr_rsp_unexpected cyc=%0d id=%0d exp=no response", cyc, rsp_id);
        else begin
          exp_id = q_id.pop_front(); res = q_res.pop_front(); rsp_cnt++;
          if (rsp_id !== IDW'(exp_id) || {rsp_cout, rsp_sum} !== res)
            $display("FAIL rr_rsp cyc=%0d id=%0d sum=%h cout=%b exp id=%0d sum=%h cout=%b", cyc, rsp_id, rsp_sum, rsp_cout, exp_id, res[31:0], res[32]);
          else n_pass++;
        end
      end
      prev_acc = (req_ready != '0);
      if (prev_acc) begin
        g = pick(req_valid, m_ptr);
        n_total++;
        if (req_ready !== onehot(g) || g != acc_cnt % NREQ)
          $display("FAIL rr_grant cyc=%0d ready=%b exp=%b", cyc, req_ready, onehot(acc_cnt % NREQ));
        else n_pass++;
        if (last_acc >= 0) begin
          n_total++;
          if (cyc - last_acc != 2) $display("FAIL rr_spacing cyc=%0d gap=%0d exp=2", cyc, cyc - last_acc); else n_pass++;
        end
        q_id.push_back(g); q_res.push_back(ref_add(get_a(g), get_b(g), req_cin[g]));
        prev_a = get_a(g); m_ptr = (g + 1) % NREQ; acc_cnt++; last_acc = cyc;
        @(posedge clk); #1;
        set_req(g, $urandom, $urandom, 1'($urandom));
        if (acc_cnt == 8) req_valid = '0;
      end
      @(negedge clk);
    end
    n_total++;
    if (acc_cnt != 8 || rsp_cnt != 8) $display("FAIL rr_counts acc=%0d rsp=%0d exp=8/8", acc_cnt, rsp_cnt); else n_pass++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [32:0] r0, r2;
    int          g0;
    @(negedge clk);
    set_req(0, $urandom, $urandom, 1'($urandom)); req_valid = 4'b0001; rsp_ready = 1'b0;
    g0 = pick(req_valid, m_ptr); m_ptr = (g0 + 1) % NREQ;
    r0 = ref_add(get_a(0), get_b(0), req_cin[0]);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    set_req(2, $urandom, $urandom, 1'($urandom)); req_valid = 4'b0100;
    r2 = ref_add(get_a(2), get_b(2), req_cin[2]);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_cout, rsp_sum} !== r0 || req_ready !== '0)
        $display("FAIL bp_hold k=%0d rv=%b id=%0d sum=%h cout=%b ready=%b exp rv=1 id=0 sum=%h cout=%b ready=0",
                 k, rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready, r0[31:0], r0[32]);
      else n_pass++;
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    n_total++;
    if (req_ready !== 4'b0100) $display("FAIL bp_accept ready=%b exp=0100", req_ready); else n_pass++;
    m_ptr = 3;
    @(negedge clk); req_valid = '0; rsp_ready = 1'b0; #1;
    n_total++;
    if (add_en !== 1'b1 || add_a !== get_a(2) || rsp_valid !== 1'b0)
      $display("FAIL bp_exec en=%b a=%h rv=%b exp en=1 a=%h rv=0", add_en, add_a, rsp_valid, get_a(2));
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || {rsp_cout, rsp_sum} !== r2)
      $display("FAIL bp_resp rv=%b id=%0d sum=%h exp id=2 sum=%h", rsp_valid, rsp_id, rsp_sum, r2[31:0]);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    set_req(1, $urandom, $urandom, 1'($urandom)); req_valid = 4'b0010; #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL wrap_grant ready=%b exp=0010", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    req_valid = '1; rsp_ready = 1'b1; #1;
    n_total++;
    if (rsp_id !== 2'd1 || req_ready !== 4'b0100) $display("FAIL wrap_next id=%0d ready=%b exp id=1 ready=0100", rsp_id, req_ready); else n_pass++;
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) $display("FAIL wrap_resp rv=%b id=%0d exp rv=1 id=2", rsp_valid, rsp_id); else n_pass++;
    @(negedge clk); rsp_ready = 1'b0;
    m_ptr = 3;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(1, $urandom, $urandom, 1'($urandom)); req_valid = 4'b0010; #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL rmid_accept ready=%b exp=0010", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; rst_n = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b0 || add_en !== 1'b0) $display("FAIL rmid_cleared rv=%b en=%b exp 0 0", rsp_valid, add_en); else n_pass++;
    rst_n = 1'b1; m_ptr = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_total++;
      if (rsp_valid !== 1'b0 || add_en !== 1'b0) $display("FAIL rmid_quiet k=%0d rv=%b en=%b exp 0 0", k, rsp_valid, add_en); else n_pass++;
    end
    @(negedge clk);
    req_valid = '1; #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL rmid_ptr ready=%b exp=0001", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0;
    @(negedge clk); rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    m_ptr = 1;
  endtask

  task automatic test_random();
    logic            m_exec = 1'b0, m_rsp = 1'b0, e_ovf = 1'b0, r_ovf = 1'b0, window;
    int              e_id = 0, r_id = 0, g;
    logic [32:0]     e_res = '0, r_res = '0;
    logic [NREQ-1:0] pend = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, $urandom, $urandom, 1'($urandom));
        end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      window = !m_exec && (!m_rsp || rsp_ready);
      g = window ? pick(pend, m_ptr) : -1;
      n_total++;
      if (req_ready !== onehot(g)) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, onehot(g)); else n_pass++;
      n_total++;
      if (rsp_valid !== m_rsp || add_en !== m_exec)
        $display("FAIL rnd_ctrl cyc=%0d rv=%b en=%b exp rv=%b en=%b", cyc, rsp_valid, add_en, m_rsp, m_exec);
      else n_pass++;
      if (m_rsp) begin
        n_total++;
        if (rsp_id !== IDW'(r_id) || {rsp_cout, rsp_sum} !== r_res)
          $display("FAIL rnd_rsp cyc=%0d id=%0d sum=%h cout=%b exp id=%0d sum=%h cout=%b", cyc, rsp_id, rsp_sum, rsp_cout, r_id, r_res[31:0], r_res[32]);
        else n_pass++;
`ifdef ADDER_SHARE_OVF_EN
        n_total++;
        if (rsp_ovf !== r_ovf) $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, rsp_ovf, r_ovf); else n_pass++;
`endif
      end
      if (m_rsp && rsp_ready) m_rsp = 1'b0;
      if (m_exec) begin
        m_rsp = 1'b1; r_id = e_id; r_res = e_res; r_ovf = e_ovf; m_exec = 1'b0;
      end
      if (g >= 0) begin
        m_exec = 1'b1; e_id = g;
        e_res = ref_add(get_a(g), get_b(g), req_cin[g]);
        e_ovf = ref_ovf(get_a(g), get_b(g), req_cin[g]);
        m_ptr = (g + 1) % NREQ; pend[g] = 1'b0;
      end
    end
    @(negedge clk); req_valid = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_cin = '0;
    test_reset();
    test_single();
    test_carry();
    test_all_rr();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
